// File: rtl/mem_pager.sv
// mem_pager: relocatable window page mapper with access-fault capture.
// Translation is combinational; window and status registers are clocked.
module mem_pager #(
  parameter int ADDR_W    = 16,
  parameter int PAGE_BITS = 5,
  parameter int WINDOWS   = 4,
  parameter int WIN_W     = (WINDOWS > 1) ? $clog2(WINDOWS) : 1,
  parameter int RA_W      = $clog2(WINDOWS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic              vld,
  input  logic              io_sel,
  input  logic              cs,
  input  logic [RA_W-1:0]   ra,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              fix_hit,
  output logic              win_hit,
  output logic [WIN_W-1:0]  win_idx,
  output logic              mem_we,
  output logic              irq
);

  localparam logic [RA_W-1:0] STAT_RA = RA_W'(WINDOWS);

  logic [PAGE_BITS-1:0] pg_q [WINDOWS];
  logic [PAGE_BITS-1:0] pg_d [WINDOWS];
  logic [WINDOWS-1:0]   en_q, en_d;
  logic [WINDOWS-1:0]   wp_q, wp_d;

  logic [PAGE_BITS-1:0] fpage_q, fpage_d;
  logic                 ovf_q, ovf_d;
  logic                 wpf_q, wpf_d;
  logic                 pend_q, pend_d;

  logic [PAGE_BITS-1:0] page;
  logic                 miss;
  logic                 prot;
  logic                 fault;
  logic                 stat_wr;

  assign page = addr[ADDR_W-1 -: PAGE_BITS];

  // Window match; scanning downward lets the lowest index win.
  always_comb begin
    fix_hit = (page == '0);
    win_hit = 1'b0;
    win_idx = '0;
    for (int i = WINDOWS - 1; i >= 0; i--) begin
      if (en_q[i] && pg_q[i] == page && page != '0) begin
        win_hit = 1'b1;
        win_idx = WIN_W'(i);
      end
    end
  end

  // Write gating and fault classification.
  always_comb begin
    prot    = win_hit && !rw && wp_q[win_idx];
    miss    = !fix_hit && !win_hit;
    mem_we  = vld && !rw && (fix_hit || (win_hit && !wp_q[win_idx]));
    fault   = vld && !io_sel && !cs && (miss || prot);
    stat_wr = cs && !rw && (ra == STAT_RA);
  end

  // Register read mux; unused middle bits and out-of-range addresses read 0.
  always_comb begin
    dout = '0;
    for (int i = 0; i < WINDOWS; i++) begin
      if (ra == RA_W'(i)) begin
        dout[7 -: PAGE_BITS] = pg_q[i];
        dout[1]              = wp_q[i];
        dout[0]              = en_q[i];
      end
    end
    if (ra == STAT_RA) begin
      dout[7 -: PAGE_BITS] = fpage_q;
      dout[2]              = ovf_q;
      dout[1]              = wpf_q;
      dout[0]              = pend_q;
    end
  end

  // Window register writes.
  always_comb begin
    en_d = en_q;
    wp_d = wp_q;
    for (int i = 0; i < WINDOWS; i++) begin
      pg_d[i] = pg_q[i];
      if (cs && !rw && ra == RA_W'(i)) begin
        pg_d[i] = din[7 -: PAGE_BITS];
        wp_d[i] = din[1];
        en_d[i] = din[0];
      end
    end
  end

  // Fault capture; a new fault beats a simultaneous status clear.
  always_comb begin
    fpage_d = fpage_q;
    ovf_d   = ovf_q;
    wpf_d   = wpf_q;
    pend_d  = pend_q;
    if (fault) begin
      if (!pend_q || stat_wr) begin
        fpage_d = page;
        wpf_d   = prot;
        ovf_d   = 1'b0;
        pend_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (stat_wr) begin
      ovf_d  = 1'b0;
      wpf_d  = 1'b0;
      pend_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WINDOWS; i++) begin
        if (i + 1 < (1 << PAGE_BITS)) begin
          pg_q[i] <= PAGE_BITS'(i + 1);
          en_q[i] <= 1'b1;
        end else begin
          pg_q[i] <= '0;
          en_q[i] <= 1'b0;
        end
      end
      wp_q    <= '0;
      fpage_q <= '0;
      ovf_q   <= 1'b0;
      wpf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      for (int i = 0; i < WINDOWS; i++) begin
        pg_q[i] <= pg_d[i];
      end
      en_q    <= en_d;
      wp_q    <= wp_d;
      fpage_q <= fpage_d;
      ovf_q   <= ovf_d;
      wpf_q   <= wpf_d;
      pend_q  <= pend_d;
    end
  end

  assign irq = pend_q;

endmodule

// File: doc/mem_pager.md
# mem_pager

Parametrised page mapper and access-fault unit for the 8-bit CPU bus. It generalises the fixed two-window, 2 KB bank scheme to WINDOWS relocatable windows with configurable page size. Each window has an enable and a write-protect bit, and faults are latched and held until software clears them. The block sits between the CPU address bus and the on-chip SRAM blocks. It drives window-hit and window-index selects, gates SRAM write enable, and raises an interrupt on misses or protected writes.

## Interface
- ADDR_W, 16, CPU address width
- PAGE_BITS, 5, logical page number width (page = ADDR[ADDR_W-1 -: PAGE_BITS]); legal range 1..5
- WINDOWS, 4, number of relocatable windows; legal range 1..8
- WIN_W, derived = max(1, clog2(WINDOWS)), window index width
- RA_W, derived = clog2(WINDOWS+1), register address width
---
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-low
- addr  in  ADDR_W  CPU address
- rw  in  1  1 = read, 0 = write
- vld  in  1  bus cycle valid this clock
- io_sel  in  1  address decoded as I/O by top level (never faults)
- cs  in  1  register select
- ra  in  RA_W  register address
- din  in  8  CPU write data
- dout  out  8  register read data (combinational)
- fix_hit  out  1  logical page 0 (fixed SRAM)
- win_hit  out  1  some enabled window matches
- win_idx  out  WIN_W  matching window, lowest index wins
- mem_we  out  1  SRAM write enable
- irq  out  1  fault interrupt, level

## Operation
- page = addr top PAGE_BITS. fix_hit = (page==0). Window i matches when EN_i && PG_i==page && page!=0.
- win_hit/win_idx combinational. If no match, win_idx=0. If several windows match, lowest i wins.
- mem_we = vld && !rw && (fix_hit || (win_hit && !WP_win_idx)).
- Window register i (ra=i): bits[7:8-PAGE_BITS] = PG_i (left-aligned, unused middle bits read 0), bit1 = WP_i, bit0 = EN_i. Written on cs && !rw.
- Status register (ra=WINDOWS): bits[7:8-PAGE_BITS] = fault page, bit2 = OVF, bit1 = WPF (1 = protected write, 0 = miss), bit0 = PEND. Any write clears PEND, OVF and WPF. The fault page is retained.
- ra > WINDOWS: reads 0, writes ignored.
- Fault event = vld && !io_sel && !cs && (miss || protwrite).
  - miss = !fix_hit && !win_hit.
  - protwrite = win_hit && !rw && WP_win_idx.
- On a fault event with PEND=0: latch page, set WPF per type, set PEND.
- On a fault event with PEND=1: set OVF only; the first fault's info is kept.
- irq = PEND (registered).
- Reset values: window i has EN=1, WP=0, PG=i+1 if i+1 < 2^PAGE_BITS, else EN=0 and PG=0. Status is all 0, irq=0, mem_we follows inputs.

## Timing
- Translation (fix_hit, win_hit, win_idx, mem_we) is zero-latency combinational from addr, rw and registers.
- Register write takes effect at the clock edge. The new mapping is visible to translation in the next cycle.
- A fault at edge N gives PEND/irq=1 from cycle N+1.
- Status write and fault event in the same cycle: the fault wins. PEND=1 with the new page, OVF=0, WPF per the new fault.
- Window write and an access to the same page in the same cycle: translation uses the old register value.
- rst low at any edge restores reset values that edge, including mid-fault. irq drops the next cycle.
- vld=0: no fault is recorded and mem_we=0.

## Test plan
- Reset defaults (WINDOWS=4, PAGE_BITS=5): addr=$0800 -> win_hit=1, win_idx=0. addr=$2000 (page 4) -> win_hit=1, win_idx=3. addr=$2800 -> miss, and PEND=1, page=5, irq=1 in the next cycle.
- Remap: write window1 = $A1 (PG=20, EN) -> addr=$A000 gives win_idx=1. addr=$1000 now misses, status reads $11 after the fault.
- Write protect: window0 = $0B (PG=1, WP, EN). A write to $0805 -> mem_we=0, status=$0B, irq=1. A read of $0805 -> no fault, win_hit=1.
- Overflow and clear: two consecutive misses at $3000 then $3800 -> status=$35 (first page kept, OVF). Write status -> status=$30, irq=0 the next cycle. Clear plus a simultaneous miss at $4000 -> status=$41.
- Overlap priority: windows 1 and 2 both PG=7, EN -> addr=$3800 gives win_idx=1. Disable window 1 -> win_idx=2.
- Exemptions: a miss address with io_sel=1, with cs=1, or with vld=0 -> no PEND. rst low with PEND=1 -> status=0 and defaults restored.
